// File: rtl/compc_seq.sv
// Sequential magnitude comparator: scans two packed operands MSB-first, DIGIT bits
// per cycle, stops at the first differing digit and reports {gt, lt, eq, res}.
module compc_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [2*WIDTH-1:0]   data_in,
  input  logic [2:0]           mode,
  input  logic                 signed_cmp,
  output logic [3:0]           ab_out,
  output logic                 done_compc
);

  localparam int NDIG  = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int EXT_W = NDIG * DIGIT;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e             state_q, state_d;
  logic               enable_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [EXT_W-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]         mode_q, mode_d;
  logic [3:0]         ab_q, ab_d;
  logic               done_q, done_d;

  logic               start;
  logic [EXT_W-1:0]   a_ext, b_ext;
  logic [DIGIT-1:0]   dig_a, dig_b;
  logic               dig_gt, dig_lt;

  function automatic logic rel_res(input logic [2:0] m, input logic gt, input logic lt,
                                   input logic eq);
    case (m)
      3'd0:    return eq;
      3'd1:    return ~eq;
      3'd2:    return lt;
      3'd3:    return lt | eq;
      3'd4:    return gt;
      3'd5:    return gt | eq;
      default: return 1'b0;
    endcase
  endfunction

  assign start = enable & ~enable_q;

  // Signed operands become offset binary so the digit scan stays unsigned.
  always_comb begin
    a_ext            = '0;
    b_ext            = '0;
    a_ext[WIDTH-1:0] = data_in[2*WIDTH-1:WIDTH];
    b_ext[WIDTH-1:0] = data_in[WIDTH-1:0];
    a_ext[WIDTH-1]   = data_in[2*WIDTH-1] ^ signed_cmp;
    b_ext[WIDTH-1]   = data_in[WIDTH-1] ^ signed_cmp;
  end

  assign dig_a  = a_q[idx_q*DIGIT +: DIGIT];
  assign dig_b  = b_q[idx_q*DIGIT +: DIGIT];
  assign dig_gt = dig_a > dig_b;
  assign dig_lt = dig_a < dig_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      enable_q <= 1'b0;
      idx_q    <= '0;
      ab_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable;
      idx_q    <= idx_d;
      ab_q     <= ab_d;
      done_q   <= done_d;
    end
  end

  // Captured operands are pure data and carry no reset.
  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    mode_q <= mode_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    ab_d    = ab_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_ext;
          b_d     = b_ext;
          mode_d  = mode;
          idx_d   = IDX_W'(NDIG - 1);
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (dig_a != dig_b) begin
          ab_d    = {dig_gt, dig_lt, 1'b0, rel_res(mode_q, dig_gt, dig_lt, 1'b0)};
          done_d  = 1'b1;
          state_d = DONE;
        end else if (idx_q == '0) begin
          ab_d    = {2'b00, 1'b1, rel_res(mode_q, 1'b0, 1'b0, 1'b1)};
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (!enable) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ab_out     = ab_q;
    done_compc = done_q;
  end

endmodule

// File: tb/tb_compc_seq.sv
// Directed bench for compc_seq (WIDTH=8, DIGIT=2): expected result and latency are
// queued when a comparison is launched and popped when done_compc rises.
module tb_compc_seq;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] data_in;
  logic [2:0]  mode;
  logic        signed_cmp;
  logic [3:0]  ab_out;
  logic        done_compc;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [3:0] exp_ab_q[$];
  int         exp_k_q[$];

  compc_seq #(.WIDTH(8), .DIGIT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .data_in    (data_in),
    .mode       (mode),
    .signed_cmp (signed_cmp),
    .ab_out     (ab_out),
    .done_compc (done_compc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for done_compc after the capture edge, then scores against the queue head.
  task automatic wait_result(input string tag);
    int cnt;
    logic [3:0] e_ab;
    int e_k;
    cnt = 0;
    while (cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
      if (done_compc === 1'b1) break;
    end
    e_ab = exp_ab_q.pop_front();
    e_k  = exp_k_q.pop_front();
    check({tag, "_latency"}, cnt, e_k);
    check({tag, "_ab"}, {28'd0, ab_out}, {28'd0, e_ab});
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic [2:0] m,
                        input logic s, input logic [3:0] e_ab, input int e_k,
                        input string tag);
    @(negedge clk);
    data_in    = {a, b};
    mode       = m;
    signed_cmp = s;
    enable     = 1'b1;
    exp_ab_q.push_back(e_ab);
    exp_k_q.push_back(e_k);
    @(posedge clk);
    #1;
    data_in    = ~data_in;
    mode       = 3'd7;
    signed_cmp = ~s;
    wait_result(tag);
  endtask

  task automatic release_en(input logic [3:0] e_ab, input string tag);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_done_fall"}, {31'd0, done_compc}, 32'd0);
    check({tag, "_ab_hold"}, {28'd0, ab_out}, {28'd0, e_ab});
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    data_in    = '0;
    mode       = '0;
    signed_cmp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ab", {28'd0, ab_out}, 32'd0);
    check("reset_done", {31'd0, done_compc}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    launch(8'h5A, 8'h5A, 3'd0, 1'b0, 4'b0011, 4, "eq_equal");
    release_en(4'b0011, "eq_equal");
    launch(8'h80, 8'h01, 3'd4, 1'b0, 4'b1001, 1, "gt_unsigned");
    release_en(4'b1001, "gt_unsigned");
    launch(8'h80, 8'h01, 3'd4, 1'b1, 4'b0100, 1, "gt_signed");
    release_en(4'b0100, "gt_signed");
    launch(8'hFF, 8'hFE, 3'd5, 1'b1, 4'b1001, 4, "ge_signed");
    release_en(4'b1001, "ge_signed");
    launch(8'h5A, 8'h5A, 3'd6, 1'b0, 4'b0010, 4, "reserved_mode");
    release_en(4'b0010, "reserved_mode");

    // Abort: enable dropped after E+2, sampled low at E+3 before the scan completes.
    @(negedge clk);
    data_in = {8'h33, 8'h33};
    mode    = 3'd0;
    enable  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("abort_done", {31'd0, done_compc}, 32'd0);
    end
    check("abort_ab_hold", {28'd0, ab_out}, 32'h2);
    launch(8'h10, 8'h20, 3'd2, 1'b0, 4'b0101, 2, "lt_after_abort");
    release_en(4'b0101, "lt_after_abort");

    // Reset mid-scan with enable held high through release.
    @(negedge clk);
    data_in = {8'h33, 8'h33};
    mode    = 3'd0;
    enable  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midscan_rst_ab", {28'd0, ab_out}, 32'd0);
    check("midscan_rst_done", {31'd0, done_compc}, 32'd0);
    @(negedge clk);
    data_in = {8'h5A, 8'h3C};
    mode    = 3'd4;
    exp_ab_q.push_back(4'b1001);
    exp_k_q.push_back(1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    wait_result("post_reset");

    // Enable held high: result must stay put until enable is sampled low.
    repeat (10) begin
      @(posedge clk);
      #1;
      check("hold_done", {31'd0, done_compc}, 32'd1);
    end
    check("hold_ab", {28'd0, ab_out}, 32'h9);
    release_en(4'b1001, "handshake");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/compc_seq.md
# compc_seq

Parametrised, multi-mode sequential magnitude comparator; next generation of the 4-bit enable-strobed equality comparator in the comparator slice of the ALU. Compares two packed WIDTH-bit operands MSB-first, DIGIT bits per cycle, with early termination at the first differing digit. Supports six relational modes plus signed or unsigned interpretation. Keeps the enable-in / done-out handshake the ALU sequencer already uses.

## Interface
- WIDTH, default 8: operand width in bits; must be ≥ 1.
- DIGIT, default 2: bits compared per scan cycle; 1 ≤ DIGIT ≤ WIDTH.
- NDIG (localparam) = ceil(WIDTH/DIGIT): number of digits per operand.
- clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  level request; a 0→1 transition, sampled on clk, starts one comparison.
- data_in  input  2*WIDTH  packed operands: A = data_in[2*WIDTH-1:WIDTH], B = data_in[WIDTH-1:0].
- mode  input  3  relation: 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE; 6 and 7 reserved (result 0).
- signed_cmp  input  1  1 = two's-complement operands, 0 = unsigned.
- ab_out  output  4  {gt, lt, eq, res}; res is the selected relation (A mode B).
- done_compc  output  1  result valid; high from completion until enable is seen low.

## Operation
- State register: IDLE, SCAN, DONE. Register enable_q holds enable delayed one cycle. Start = enable & ~enable_q.
- IDLE: on start, capture data_in, mode and signed_cmp. If signed_cmp=1, invert the MSB of both operands (offset binary); the comparison is then unsigned. Zero-extend both operands to NDIG*DIGIT bits at the top. Set idx = NDIG-1 and go to SCAN.
- SCAN, each cycle: compare digit idx of A and B.
  - Digits differ: set gt/lt from the digit magnitude, eq=0, and go to DONE.
  - Digits equal and idx = 0: eq=1, gt=lt=0, and go to DONE.
  - Otherwise: decrement idx.
- On entry to DONE, register ab_out and set done_compc=1. Compute res from gt/lt/eq and the captured mode. Reserved modes give res=0.
- DONE: hold ab_out and done_compc while enable=1. When enable is sampled 0, go to IDLE and clear done_compc. ab_out retains its last value.
- Abort: enable sampled 0 during SCAN → go to IDLE. done_compc stays 0 and ab_out is unchanged.
- Inputs that change after capture have no effect on the comparison in flight.
- No new comparison starts until the FSM is in IDLE. A start (0→1 edge) seen outside IDLE is ignored. If enable is already high on return to IDLE, no start occurs, because no edge is seen.

## Timing
- Reset, when rst=1 at a clk edge, dominates everything: state=IDLE, enable_q=0, ab_out=4'b0000, done_compc=0, idx=0.
- Reset asserted mid-SCAN or in DONE abandons the operation. Outputs are 0 on the next cycle.
- enable held high through reset release: enable_q=0, so the first cycle after reset sees a start and captures.
- Latency: let E be the clk edge where start is seen (capture). done_compc and ab_out are valid after edge E+k. k is the number of digits examined, 1 ≤ k ≤ NDIG. Worst case (equal operands) is E+NDIG.
- done_compc falls at the first edge after E+k at which enable is sampled 0.
- Back-to-back: the minimum enable low time is 1 cycle. The next rise is then detected on the following edge.
- One result per handshake. No pipelining.

## Test plan
All scenarios use WIDTH=8, DIGIT=2 (NDIG=4).
- Equal, EQ mode: A=0x5A, B=0x5A, mode=0, unsigned, enable↑ → done_compc at E+4, ab_out=4'b0011.
- Early exit, GT mode: A=0x80, B=0x01, mode=4, unsigned → done_compc at E+1, ab_out=4'b1001.
- Signed, GT mode: same data, signed_cmp=1, mode=4 (−128 vs 1) → done_compc at E+1, ab_out=4'b0100.
- Signed, GE mode: A=0xFF, B=0xFE, mode=5, signed_cmp=1 (−1 vs −2) → digit 0 differs, done_compc at E+4, ab_out=4'b1001.
- Abort: A=B=0x33, drop enable after E+2 → done_compc never rises and ab_out keeps its prior value. Next enable↑ with A=0x10, B=0x20, mode=2 → ab_out=4'b0101.
- Reset mid-SCAN: rst=1 at E+2 → ab_out=0 and done_compc=0 next cycle. Enable still high at release → a new capture occurs on the first post-reset edge. Handshake: enable held high 10 cycles after done → done_compc stays 1 and falls one edge after enable is sampled low.
